// File: rtl/cba_multicycle_add_ctrl_pkg.sv
// Shared types and constants for the multicycle carry-bypass add controller.
package cba_multicycle_add_ctrl_pkg;

   localparam int CBA_BLOCK_LEN = 4;

   typedef enum logic [1:0] {
      CBA_ST_IDLE = 2'd0,
      CBA_ST_RUN  = 2'd1,
      CBA_ST_DONE = 2'd2
   } cba_state_e;

   // Slice index width; a single-slice build still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cba_multicycle_add_ctrl_if.sv
// Operand/result handshake bundle between producer, adder controller and consumer.
interface cba_multicycle_add_ctrl_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/cba_multicycle_add_ctrl_adder.sv
// One carry-bypass adder slice: ripple carry with a bypass when every bit propagates.
module cba_multicycle_add_ctrl_adder #(
   parameter int BL = 4
) (
   input  logic [BL-1:0] a,
   input  logic [BL-1:0] b,
   input  logic          c,
   output logic [BL-1:0] sum,
   output logic          cout
);
   logic [BL:0]   carry;
   logic [BL-1:0] prop;

   assign carry[0] = c;

   generate
      for (genvar gi = 0; gi < BL; gi++) begin : g_bit
         assign prop[gi]      = a[gi] ^ b[gi];
         assign sum[gi]       = prop[gi] ^ carry[gi];
         assign carry[gi+1]   = (a[gi] & b[gi]) | (prop[gi] & carry[gi]);
      end
   endgenerate

   assign cout = (&prop) ? c : carry[BL];
endmodule

// File: rtl/cba_multicycle_add_ctrl.sv
// Time-shares one adder slice across NUM_BLOCKS cycles, LSB slice first, with the
// inter-slice carry held in a register.
module cba_multicycle_add_ctrl
   import cba_multicycle_add_ctrl_pkg::*;
#(
   parameter int NUM_BLOCKS = 4,
   parameter int BLOCK_LEN  = CBA_BLOCK_LEN
) (
   input  logic                      clk,
   input  logic                      rst,
   cba_multicycle_add_ctrl_if.slave  bus
);
   localparam int W    = BLOCK_LEN * NUM_BLOCKS;
   localparam int IDXW = idx_width(NUM_BLOCKS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BLOCKS - 1);

   cba_state_e             state_reg, state_next;
   logic [IDXW-1:0]        idx_reg;
   logic                   carry_reg;
   logic [W-1:0]           a_reg, b_reg;
   logic [W-1:0]           sum_reg;
   logic                   cout_reg;
   logic                   accept;
   logic                   in_ready_next;
   logic [BLOCK_LEN-1:0]   slice_a, slice_b, slice_sum;
   logic                   slice_cout;

   assign slice_a = a_reg[idx_reg*BLOCK_LEN +: BLOCK_LEN];
   assign slice_b = b_reg[idx_reg*BLOCK_LEN +: BLOCK_LEN];

   cba_multicycle_add_ctrl_adder #(.BL(BLOCK_LEN)) u_slice (
      slice_a, slice_b, carry_reg, slice_sum, slice_cout
   );

   always_comb begin
      state_next    = state_reg;
      in_ready_next = 1'b0;
      accept        = 1'b0;
      case (state_reg)
         CBA_ST_IDLE: begin
            in_ready_next = 1'b1;
            if (bus.in_valid) begin
               accept     = 1'b1;
               state_next = CBA_ST_RUN;
            end
         end
         CBA_ST_RUN: begin
            if (idx_reg == LAST_IDX) state_next = CBA_ST_DONE;
         end
         CBA_ST_DONE: begin
            // Handing off the result frees the block to take the next operands at once.
            if (bus.out_ready) begin
               in_ready_next = 1'b1;
               if (bus.in_valid) begin
                  accept     = 1'b1;
                  state_next = CBA_ST_RUN;
               end else begin
                  state_next = CBA_ST_IDLE;
               end
            end
         end
         default: state_next = CBA_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= CBA_ST_IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx_reg   <= '0;
         end
         if (state_reg == CBA_ST_RUN) begin
            sum_reg[idx_reg*BLOCK_LEN +: BLOCK_LEN] <= slice_sum;
            carry_reg <= slice_cout;
            if (idx_reg == LAST_IDX) cout_reg <= slice_cout;
            else                     idx_reg  <= idx_reg + 1'b1;
         end
      end
   end

   assign bus.in_ready  = in_ready_next;
   assign bus.out_valid = (state_reg == CBA_ST_DONE);
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
endmodule
